// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble and machine-status controller for the five-stage Y86-64 pipeline.
// Optional saturating performance counters are enabled with PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             cpu_halted,
    output logic [2:0]       cpu_stat
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`endif
);

    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_IRET   = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [2:0] S_AOK    = 3'd1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state, state_next;

    logic load_use, ret_in, mispredict, m_exc, w_exc;

    // Hazard detection; any icode not named here compares false and is harmless.
    assign load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                        (E_dstM != RNONE) &&
                        ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_in     = (D_icode == I_IRET) || (E_icode == I_IRET) || (M_icode == I_IRET);
    assign mispredict = (E_icode == I_JXX) && !e_Cnd;
    assign m_exc      = (m_stat != S_AOK);
    assign w_exc      = (W_stat != S_AOK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            cpu_halted <= 1'b0;
            cpu_stat   <= S_AOK;
        end else begin
            state <= state_next;
            if ((state != ST_HALTED) && (state_next == ST_HALTED)) begin
                cpu_halted <= 1'b1;
                cpu_stat   <= W_stat;
            end
        end
    end

    // Next state and pipeline-register controls; everything is held low during reset.
    always_comb begin
        state_next = state;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        W_stall    = 1'b0;
        set_cc     = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN, ST_DRAIN: begin
                    if (w_exc)
                        state_next = ST_HALTED;
                    else if (m_exc)
                        state_next = ST_DRAIN;
                    F_stall  = load_use | ret_in;
                    D_stall  = load_use;
                    D_bubble = mispredict | (ret_in & ~load_use);
                    E_bubble = mispredict | load_use;
                    M_bubble = m_exc | w_exc;
                    W_stall  = w_exc;
                    set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
                end
                ST_HALTED: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating activity counters, frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            mispred_cnt <= '0;
        end else if (state != ST_HALTED) begin
            if (cyc_cnt != '1)
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (F_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/bubble controller for the five-stage Y86-64 pipeline.
- Drives the stall and bubble inputs of the F/D/E/M/W pipeline registers and the condition-code write enable.
- Sequences machine status from run, through exception drain, to halted.
- Takes stage icodes, register IDs and status from the decode, execute, memory and writeback latches.

Parameters:
- CNT_W, 32, width of performance counters (saturating).
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- D_icode  in  4  icode in decode register.
- d_srcA  in  4  decode source A.
- d_srcB  in  4  decode source B.
- E_icode  in  4  icode in execute register.
- E_dstM  in  4  execute-stage memory destination.
- e_Cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode in memory register.
- m_stat  in  3  status produced by memory stage.
- W_stat  in  3  status in writeback register.
- F_stall  out  1  hold fetch PC register.
- D_stall  out  1  hold decode register.
- D_bubble  out  1  load NOP into decode register.
- E_bubble  out  1  load NOP into execute register.
- M_bubble  out  1  load NOP into memory register.
- W_stall  out  1  hold writeback register.
- set_cc  out  1  condition-code write enable.
- cpu_halted  out  1  registered; high in HALTED.
- cpu_stat  out  3  registered final machine status.

Behaviour:
- Encodings:
  - icode: HALT=0, NOP=1, OPQ=6, JXX=7, IRET=9, MRMOVQ=5, POPQ=B.
  - stat: AOK=1, HLT=2, ADR=3, INS=4.
- Hazard terms (combinational, same cycle as inputs):
  - load_use = E_icode in {MRMOVQ,POPQ} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - ret_in = IRET present in any of D_icode, E_icode, M_icode.
  - mispredict = E_icode==JXX && !e_Cnd.
  - m_exc = m_stat!=AOK.
  - w_exc = W_stat!=AOK.
- Outputs in RUN and DRAIN:
  - F_stall = load_use | ret_in.
  - D_stall = load_use.
  - D_bubble = mispredict | (ret_in & ~load_use).
  - E_bubble = mispredict | load_use.
  - M_bubble = m_exc | w_exc.
  - W_stall = w_exc.
  - set_cc = E_icode==OPQ & ~m_exc & ~w_exc.
- Priority: load_use beats ret_in for D (stall, no bubble); mispredict and load_use together give E_bubble once, with D_bubble asserted.
- FSM, 2 bits, updated on clk rising edge:
  - RUN: m_exc & ~w_exc -> DRAIN; w_exc -> HALTED (w_exc wins if both high).
  - DRAIN: w_exc -> HALTED; otherwise stay. m_stat returning to AOK does not return to RUN; only reset leaves DRAIN.
  - HALTED: sticky until rst.
- In HALTED, regardless of inputs: F_stall=D_stall=W_stall=1, D_bubble=0, E_bubble=M_bubble=1, set_cc=0.
- cpu_stat:
  - Captures W_stat on the RUN/DRAIN->HALTED edge.
  - Equals AOK at all other times before halt.
  - Holds its value while HALTED.
- cpu_halted: 1 from the cycle after entering HALTED.
- Reset (async, rst=1):
  - state=RUN, cpu_halted=0, cpu_stat=AOK.
  - All stall/bubble outputs and set_cc forced 0 while rst high, including mid-drain or mid-halt.
  - Counters cleared.
- No X propagation: undefined icodes are treated as non-hazard.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, add outputs:
  - cyc_cnt: counts cycles not in HALTED.
  - stall_cnt: counts cycles with F_stall=1 in RUN/DRAIN.
  - mispred_cnt: counts cycles with mispredict=1 in RUN/DRAIN.
- Each counter is CNT_W wide, saturates at all-ones, and is cleared by rst.
- When not defined, none of these ports or registers exist; all other behaviour is identical.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; same with E_dstM=F -> all 0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 -> all 0.
- Ret: D_icode=9, no load_use -> F_stall=1, D_bubble=1; add load_use on d_srcB -> D_stall=1, D_bubble=0.
- Exception drain: m_stat=3 for one cycle -> M_bubble=1, set_cc=0 with E_icode=6, state DRAIN; next cycle W_stat=3 -> HALTED, cpu_halted=1, cpu_stat=3, all stalls held over 10 idle cycles.
- Simultaneous: m_stat=2 and W_stat=2 in the same cycle from RUN -> directly HALTED, cpu_stat=2.
- Reset mid-halt: assert rst asynchronously between edges while HALTED -> outputs 0 immediately, cpu_stat=1, and (with PIPE_PERF_CNT_EN) counters=0; release -> resumes RUN.
